// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } req_id_t;

  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, DMA port and memory port of the arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req and payload until their gnt is seen.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_last;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin pick: the port that did not win last gets a tie.
// Latency: combinational.
// Backpressure: none; losers simply keep requesting.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,      // bit 0 = core, bit 1 = DMA
  input  req_id_t    rr_last,
  output logic       win_vld,
  output req_id_t    winner
);

  // Single requester wins outright; on a tie the previous loser wins.
  always_comb begin
    win_vld = |req;
    winner  = CORE;
    if (req[0] && req[1]) winner = (rr_last == CORE) ? DMA : CORE;
    else if (req[1])      winner = DMA;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between core and DMA;
// optional grant/stall counters under DMEM_ARB_STATS_EN.
// Latency: writes at the grant edge, read data one cycle after grant; backpressure by withholding gnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]    stat_core_grants,
  output logic [31:0]    stat_dma_grants,
  output logic [31:0]    stat_core_stall
`endif
);

  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

  state_t            state_q, state_d;
  req_id_t           rr_last_q, rr_last_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              core_gnt_c, dma_gnt_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic              pick_vld;
  req_id_t           pick_win;

  rr_pick2 u_pick (
    .req     ({bus.dma_req, bus.core_req}),
    .rr_last (rr_last_q),
    .win_vld (pick_vld),
    .winner  (pick_win)
  );

  // Grant decision, next-state, memory mux and read-return capture.
  always_comb begin
    core_gnt_c    = 1'b0;
    dma_gnt_c     = 1'b0;
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    beat_cnt_d    = beat_cnt_q;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            rr_last_d = pick_win;
            if (pick_win == CORE) begin
              core_gnt_c = 1'b1;
            end else begin
              dma_gnt_c = 1'b1;
              // A multi-beat burst keeps the grant; with a cap of 1 it never does.
              if (!bus.dma_last && (MAX_BURST > 1)) begin
                state_d    = BURST;
                beat_cnt_d = 8'd1;
              end
            end
          end
        end
        BURST: begin
          if (bus.dma_req) begin
            if (beat_cnt_q < BURST_CAP) begin
              dma_gnt_c  = 1'b1;
              rr_last_d  = DMA;
              beat_cnt_d = beat_cnt_q + 8'd1;
            end else if (bus.core_req) begin
              // Cap reached: hand one slot to the core, DMA re-arbitrates later.
              core_gnt_c = 1'b1;
              rr_last_d  = CORE;
              state_d    = IDLE;
              beat_cnt_d = 8'd0;
            end else begin
              // Cap reached but core idle: keep streaming, count stays saturated.
              dma_gnt_c  = 1'b1;
              rr_last_d  = DMA;
            end
            if (dma_gnt_c && bus.dma_last) begin
              state_d    = IDLE;
              beat_cnt_d = 8'd0;
            end
          end else if (bus.core_req) begin
            // Paused burst: core may slip in, burst context is kept.
            core_gnt_c = 1'b1;
            rr_last_d  = CORE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (core_gnt_c) begin
      mem_we_c    = bus.core_we;
      mem_addr_c  = bus.core_addr;
      mem_wdata_c = bus.core_wdata;
    end else if (dma_gnt_c) begin
      mem_we_c    = bus.dma_we;
      mem_addr_c  = bus.dma_addr;
      mem_wdata_c = bus.dma_wdata;
    end

    core_rvalid_d = core_gnt_c && !bus.core_we;
    dma_rvalid_d  = dma_gnt_c && !bus.dma_we;
    core_rdata_d  = core_rvalid_d ? bus.mem_rdata : core_rdata_q;
    dma_rdata_d   = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;
  end

  // Arbitration state and registered read-return outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_last_q     <= DMA;
      beat_cnt_q    <= 8'd0;
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dma_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      beat_cnt_q    <= beat_cnt_d;
      core_rvalid_q <= core_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  assign bus.core_gnt    = core_gnt_c;
  assign bus.dma_gnt     = dma_gnt_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.dma_rvalid  = dma_rvalid_q;
  assign bus.dma_rdata   = dma_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_grants_q, stat_core_grants_d;
  logic [31:0] stat_dma_grants_q, stat_dma_grants_d;
  logic [31:0] stat_core_stall_q, stat_core_stall_d;

  // Free-running wrap-around event counters.
  always_comb begin
    stat_core_grants_d = stat_core_grants_q + {31'd0, core_gnt_c};
    stat_dma_grants_d  = stat_dma_grants_q + {31'd0, dma_gnt_c};
    stat_core_stall_d  = stat_core_stall_q + {31'd0, bus.core_req && !core_gnt_c};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_core_grants_q <= 32'd0;
      stat_dma_grants_q  <= 32'd0;
      stat_core_stall_q  <= 32'd0;
    end else begin
      stat_core_grants_q <= stat_core_grants_d;
      stat_dma_grants_q  <= stat_dma_grants_d;
      stat_core_stall_q  <= stat_core_stall_d;
    end
  end

  assign stat_core_grants = stat_core_grants_q;
  assign stat_dma_grants  = stat_dma_grants_q;
  assign stat_core_stall  = stat_core_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read memory model.
// Latency: checks grants in the request cycle and rvalid/rdata one cycle later.
// Backpressure: requests are held until the expected grant cycle.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_grants, stat_dma_grants, stat_core_stall;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_core_grants (stat_core_grants),
    .stat_dma_grants  (stat_dma_grants),
    .stat_core_stall  (stat_core_stall)
`endif
  );

  // Memory model: untouched words return a known pattern, written words their data.
  logic [31:0] mem_data [0:255];
  bit          mem_wr   [0:255];

  function automatic logic [31:0] init_word(input int idx);
    return (idx == 4) ? 32'hDEAD_BEEF : (32'hA000_0000 | 32'(idx));
  endfunction

  function automatic logic [31:0] mem_word(input int idx);
    return mem_wr[idx] ? mem_data[idx] : init_word(idx);
  endfunction

  assign bus.mem_rdata = mem_word(int'(bus.mem_addr[9:2]));

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem_data[bus.mem_addr[9:2]] <= bus.mem_wdata;
      mem_wr[bus.mem_addr[9:2]]   <= 1'b1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_core(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.core_req   = req;
    bus.core_we    = we;
    bus.core_addr  = addr;
    bus.core_wdata = wd;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic last);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wd;
    bus.dma_last  = last;
  endtask

  initial begin
    int beat;
    logic exp_core;
    reset = 1'b1;
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset: outputs cleared, no grants even with both requesting stores.
    set_core(1'b1, 1'b1, 32'h20, 32'h1111_1111);
    set_dma(1'b1, 1'b1, 32'h24, 32'h2222_2222, 1'b1);
    #1;
    check_eq("rst_core_gnt", 32'(bus.core_gnt), 32'd0);
    check_eq("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
    check_eq("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check_eq("rst_core_rdata", bus.core_rdata, 32'd0);
    check_eq("rst_dma_rdata", bus.dma_rdata, 32'd0);

    // Contention after reset: core first, then alternation.
    reset = 1'b0;
    #1;
    check_eq("cont1_core_gnt", 32'(bus.core_gnt), 32'd1);
    check_eq("cont1_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_eq("cont1_mem_addr", bus.mem_addr, 32'h20);
    check_eq("cont1_mem_wdata", bus.mem_wdata, 32'h1111_1111);
    check_eq("cont1_mem_we", 32'(bus.mem_we), 32'd1);
    tick();
    set_core(1'b1, 1'b1, 32'h28, 32'h3333_3333);
    #1;
    check_eq("cont2_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    check_eq("cont2_core_gnt", 32'(bus.core_gnt), 32'd0);
    check_eq("cont2_mem_addr", bus.mem_addr, 32'h24);
    tick();
    set_dma(1'b1, 1'b1, 32'h2C, 32'h4444_4444, 1'b1);
    #1;
    check_eq("cont3_core_gnt", 32'(bus.core_gnt), 32'd1);
    check_eq("cont3_mem_addr", bus.mem_addr, 32'h28);
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check_eq("cont4_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    check_eq("cont4_mem_addr", bus.mem_addr, 32'h2C);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("cont_wr_no_rvalid", 32'({bus.core_rvalid, bus.dma_rvalid}), 32'd0);
    check_eq("cont_mem8", mem_word(8), 32'h1111_1111);
    check_eq("cont_mem9", mem_word(9), 32'h2222_2222);
    check_eq("cont_mem10", mem_word(10), 32'h3333_3333);
    check_eq("cont_mem11", mem_word(11), 32'h4444_4444);

    // Single core load of word 4.
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check_eq("load_core_gnt", 32'(bus.core_gnt), 32'd1);
    check_eq("load_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_eq("load_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("load_rvalid", 32'(bus.core_rvalid), 32'd1);
    check_eq("load_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    check_eq("load_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    tick();
    check_eq("load_rvalid_drop", 32'(bus.core_rvalid), 32'd0);
    check_eq("load_rdata_hold", bus.core_rdata, 32'hDEAD_BEEF);

    // DMA 4-beat write burst, core idle.
    for (int i = 0; i < 4; i++) begin
      set_dma(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i), (i == 3));
      #1;
      check_eq($sformatf("burst4_gnt%0d", i), 32'(bus.dma_gnt), 32'd1);
      check_eq($sformatf("burst4_addr%0d", i), bus.mem_addr, 32'h100 + 32'(4 * i));
      tick();
    end
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("burst4_mem%0d", i), mem_word(64 + i), 32'hB0 + 32'(i));
    // Back in IDLE with DMA last: core wins the tie.
    set_core(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b1, 32'h200, 32'hD000_0000, 1'b0);
    #1;
    check_eq("burst4_idle_core_gnt", 32'(bus.core_gnt), 32'd1);
    tick();
    check_eq("burst4_rvalid", 32'(bus.core_rvalid), 32'd1);

    // 12-beat DMA burst against a busy core: 8 DMA, 1 core, 4 DMA, then core.
    set_core(1'b1, 1'b1, 32'h30, 32'hC0C0_C0C0);
    beat = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      exp_core = (cyc == 8) || (cyc == 13);
      if (beat < 12) set_dma(1'b1, 1'b1, 32'h200 + 32'(4 * beat), 32'hD000_0000 + 32'(beat), (beat == 11));
      else           set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      check_eq($sformatf("cap_core_gnt%0d", cyc), 32'(bus.core_gnt), 32'(exp_core));
      check_eq($sformatf("cap_dma_gnt%0d", cyc), 32'(bus.dma_gnt), 32'(!exp_core));
      tick();
      if (!exp_core) beat++;
      if (cyc == 8) set_core(1'b1, 1'b1, 32'h34, 32'hC1C1_C1C1);
      if (cyc == 13) set_core(1'b0, 1'b0, 32'h0, 32'h0);
    end
    check_eq("cap_mem_core0", mem_word(12), 32'hC0C0_C0C0);
    check_eq("cap_mem_core1", mem_word(13), 32'hC1C1_C1C1);
    check_eq("cap_mem_beat7", mem_word(135), 32'hD000_0007);
    check_eq("cap_mem_beat11", mem_word(139), 32'hD000_000B);

    // DMA read burst interrupted by reset on its third beat.
    set_dma(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    #1;
    check_eq("rb_gnt0", 32'(bus.dma_gnt), 32'd1);
    tick();
    check_eq("rb_rvalid0", 32'(bus.dma_rvalid), 32'd1);
    check_eq("rb_rdata0", bus.dma_rdata, 32'hA000_0010);
    set_dma(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    #1;
    check_eq("rb_gnt1", 32'(bus.dma_gnt), 32'd1);
    tick();
    check_eq("rb_rdata1", bus.dma_rdata, 32'hA000_0011);
    set_dma(1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
    set_core(1'b1, 1'b1, 32'h50, 32'h5555_5555);
    reset = 1'b1;
    #1;
    check_eq("rb_rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_eq("rb_rst_core_gnt", 32'(bus.core_gnt), 32'd0);
    check_eq("rb_rst_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    check_eq("rb_rst_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check_eq("rb_rst_rdata", bus.dma_rdata, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rb_post_core_gnt", 32'(bus.core_gnt), 32'd1);
    check_eq("rb_post_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check_eq("rb_post_addr", bus.mem_addr, 32'h50);
    tick();
    check_eq("rb_post_no_rvalid", 32'(bus.dma_rvalid), 32'd0);
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
    #1;
    check_eq("rb_resume_gnt", 32'(bus.dma_gnt), 32'd1);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("rb_resume_rvalid", 32'(bus.dma_rvalid), 32'd1);
    check_eq("rb_resume_rdata", bus.dma_rdata, 32'hA000_0012);

    // Counter scenario: 5 core grants, 3 DMA grants, 2 core stalls.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 0; s < 8; s++) begin
      set_core(s < 7, 1'b1, 32'h60 + 32'(4 * s), 32'(s));
      set_dma((s < 4) || (s == 7), 1'b1, 32'h80 + 32'(4 * s), 32'(s), 1'b1);
      tick();
    end
    set_core(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("stat_seq_mem_core6", mem_word(30), 32'd6);
    check_eq("stat_seq_mem_dma7", mem_word(39), 32'd7);
`ifdef DMEM_ARB_STATS_EN
    check_eq("stat_core_grants", stat_core_grants, 32'd5);
    check_eq("stat_dma_grants", stat_dma_grants, 32'd3);
    check_eq("stat_core_stall", stat_core_stall, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("stat_rst_core", stat_core_grants, 32'd0);
    check_eq("stat_rst_dma", stat_dma_grants, 32'd0);
    check_eq("stat_rst_stall", stat_core_stall, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path and a DMA/debug port.
- Performs at most one memory access per cycle.
- Arbitrates between the two requesters with round-robin priority. DMA bursts hold the grant, limited by a beat cap so the core cannot starve.
- Read data from the combinational-read memory is registered and returned to the granted requester one cycle later.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data word width.
- MAX_BURST, 8, maximum consecutive DMA grants before the core must be offered the memory (range 1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core requests an access this cycle.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  core byte address.
- core_wdata  in  DATA_W  core store data.
- core_gnt  out  1  core access performed at this clock edge.
- core_rvalid  out  1  core_rdata valid (the cycle after a load grant).
- core_rdata  out  DATA_W  core load data.
- dma_req  in  1  DMA requests an access.
- dma_we  in  1  1 = write.
- dma_addr  in  ADDR_W  DMA byte address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_last  in  1  this beat ends the DMA burst.
- dma_gnt  out  1  DMA access performed at this edge.
- dma_rvalid  out  1  dma_rdata valid.
- dma_rdata  out  DATA_W  DMA read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address (memory uses bits [ADDR_W-1:2]).
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational memory read data.

Behaviour:
- Grants are combinational from requests and the current state.
- Exactly one of core_gnt/dma_gnt may be high in a cycle.
- mem_addr, mem_wdata and mem_we are muxed from the granted port.
- mem_we = granted_we & gnt. When nothing is granted, mem_we=0 and mem_addr/mem_wdata=0.
- States:
  - IDLE: no burst in progress.
  - BURST: DMA holds the memory.
  - Registers: rr_last (last winner; 0=core, 1=DMA), beat_cnt (8-bit).
- IDLE transitions:
  - Single requester: that requester is granted.
  - Both requesting: grant the port not equal to rr_last.
  - DMA granted with dma_last=0 and MAX_BURST>1: go to BURST, beat_cnt=1.
  - Any grant updates rr_last to the winner.
- BURST transitions:
  - dma_req=1 and beat_cnt<MAX_BURST: grant DMA even if core_req=1; beat_cnt++.
  - On a DMA grant with dma_last=1: go to IDLE.
  - beat_cnt==MAX_BURST and core_req=1: grant core, go to IDLE, rr_last=0. The DMA burst resumes later as a fresh arbitration.
  - beat_cnt==MAX_BURST and core_req=0: grant DMA, beat_cnt stays saturated, remain in BURST.
  - dma_req=0 in BURST: no DMA grant. The core may be granted; the state stays BURST (burst paused).
- Read return:
  - On a load grant, mem_rdata is captured into the winner's rdata register at the edge.
  - The winner's rvalid is high for exactly 1 cycle after the grant.
  - rdata holds its value until the next load grant to the same port.
  - Write grants produce no rvalid.
- Latency: write completes at the grant edge. Read data is available 1 cycle after the grant.
- Reset behaviour:
  - All registered outputs are 0: core_rvalid, dma_rvalid, core_rdata, dma_rdata.
  - State=IDLE, rr_last=1 (core favoured first), beat_cnt=0.
  - While reset=1: core_gnt=dma_gnt=mem_we=0.
  - Reset mid-burst abandons the burst; no pending rvalid is issued afterwards.
- Boundaries:
  - MAX_BURST=1: BURST is never entered; pure round-robin.
  - Requesters must hold request and payload stable until granted.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_core_grants, stat_dma_grants and stat_core_stall (32-bit each).
  - stat_core_stall counts cycles with core_req=1 and core_gnt=0.
  - Counters are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - state enum: IDLE, BURST.
  - requester id enum: CORE=0, DMA=1.
  - default MAX_BURST constant.
- Sub-module rr_pick2: 2-way round-robin selector (reqs, rr_last -> winner). It is combinational and instantiated once.

Test Plan:
- Single core load: core_req=1, addr 0x10, mem word 4 = 0xDEADBEEF -> core_gnt same cycle; core_rvalid=1 with 0xDEADBEEF next cycle; dma_gnt=0.
- Contention after reset: both request stores -> core granted first (mem_addr=core_addr); next cycle DMA granted; alternation continues.
- DMA burst of 4 with dma_last on beat 4, core idle -> 4 consecutive dma_gnt; state returns to IDLE; beat addresses 0x100..0x10C written.
- Burst cap with MAX_BURST=8: DMA 12-beat burst with core_req held high -> beats 1..8 go to DMA, beat 9 goes to core, then the DMA resumes via round-robin.
- Reset asserted during beat 3 of a DMA read burst -> no further dma_rvalid; mem_we=0 during reset; after release the core wins the first contention.
- With DMEM_ARB_STATS_EN: 5 core grants, 3 DMA grants and 2 core stall cycles -> counters read 5/3/2; reset returns all counters to 0.
